// File: rtl/cordic_sequencer_if.sv
// Phase-in / cos-sin-out handshake bundle for cordic_sequencer.
// The slave side accepts phase words and returns the result pulse.
interface cordic_sequencer_if #(
    parameter int N_FRAC = 15
);
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic signed [N_FRAC:0]   phase_i;
    logic                     out_valid_o;
    logic signed [N_FRAC:0]   cos_o;
    logic signed [N_FRAC:0]   sin_o;

    modport slave (
        input  in_valid_i, phase_i,
        output in_ready_o, out_valid_o, cos_o, sin_o
    );

    modport master (
        output in_valid_i, phase_i,
        input  in_ready_o, out_valid_o, cos_o, sin_o
    );
endinterface

// File: rtl/cordic_sequencer.sv
// Iterative CORDIC controller: quadrant pre-rotation, N_ITER passes
// through one external cordic_slice, then a registered cos/sin pulse.
module cordic_sequencer #(
    parameter int N_FRAC         = 15,
    parameter int BW_SHIFT_VALUE = 4,
    parameter int N_ITER         = 16,
    parameter int X_INIT         = 19800
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    cordic_sequencer_if.slave           bus,
    output logic signed [N_FRAC:0]      slice_x_o,
    output logic signed [N_FRAC:0]      slice_y_o,
    output logic signed [N_FRAC:0]      slice_z_o,
    output logic [BW_SHIFT_VALUE-1:0]   slice_shift_o,
    output logic signed [N_FRAC:0]      slice_angle_o,
    input  logic signed [N_FRAC:0]      slice_x_i,
    input  logic signed [N_FRAC:0]      slice_y_i,
    input  logic signed [N_FRAC:0]      slice_z_i
);
    localparam int W = N_FRAC + 1;
    localparam logic signed [W-1:0] QUARTER = W'(1 << (N_FRAC - 1));
    localparam logic signed [W-1:0] XI      = W'(X_INIT);
    localparam logic [BW_SHIFT_VALUE-1:0] LAST = BW_SHIFT_VALUE'(N_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_CAPTURE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [BW_SHIFT_VALUE-1:0] r_cnt;
    logic signed [W-1:0] r_x0, r_y0, r_z0;
    logic signed [W-1:0] r_cos, r_sin;
    logic                r_out_valid;

    logic w_ready;
    logic w_accept;
    logic w_feedback;
    logic w_capture;
    logic w_iter;
    logic signed [W-1:0] w_x0, w_y0, w_z0;
    logic w_unused_z;

    // z is not needed after the last micro-rotation
    assign w_unused_z = ^slice_z_i;

    function automatic logic signed [W-1:0] atan_lut(
        input logic [BW_SHIFT_VALUE-1:0] i
    );
        unique case (int'(i))
            0:       atan_lut = W'(8192);
            1:       atan_lut = W'(4836);
            2:       atan_lut = W'(2555);
            3:       atan_lut = W'(1297);
            4:       atan_lut = W'(651);
            5:       atan_lut = W'(326);
            6:       atan_lut = W'(163);
            7:       atan_lut = W'(81);
            8:       atan_lut = W'(41);
            9:       atan_lut = W'(20);
            10:      atan_lut = W'(10);
            11:      atan_lut = W'(5);
            12:      atan_lut = W'(3);
            13:      atan_lut = W'(1);
            14:      atan_lut = W'(1);
            default: atan_lut = '0;
        endcase
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_accept) w_next = S_ITER;
            S_ITER:    if (r_cnt == LAST) w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready    = (r_state == S_IDLE) && !rst_i;
        w_iter     = (r_state == S_ITER);
        w_feedback = w_iter && (r_cnt != '0);
        w_capture  = (r_state == S_CAPTURE);
    end

    assign w_accept = bus.in_valid_i && w_ready;

    // fold |phase| > pi/2 into the CORDIC convergence range
    always_comb begin
        w_x0 = XI;
        w_y0 = '0;
        w_z0 = bus.phase_i;
        if (bus.phase_i >= QUARTER) begin
            w_x0 = '0;
            w_y0 = XI;
            w_z0 = bus.phase_i - QUARTER;
        end else if (bus.phase_i < -QUARTER) begin
            w_x0 = '0;
            w_y0 = -XI;
            w_z0 = bus.phase_i + QUARTER;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_x0        <= '0;
            r_y0        <= '0;
            r_z0        <= '0;
            r_cos       <= '0;
            r_sin       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_capture;
            if (w_accept) begin
                r_cnt <= '0;
                r_x0  <= w_x0;
                r_y0  <= w_y0;
                r_z0  <= w_z0;
            end else if (w_iter) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture) begin
                r_cos <= slice_x_i;
                r_sin <= slice_y_i;
            end
        end
    end

    assign slice_shift_o = r_cnt;
    assign slice_angle_o = atan_lut(r_cnt);
    assign slice_x_o     = w_feedback ? slice_x_i : r_x0;
    assign slice_y_o     = w_feedback ? slice_y_i : r_y0;
    assign slice_z_o     = w_feedback ? slice_z_i : r_z0;

    assign bus.in_ready_o  = w_ready;
    assign bus.out_valid_o = r_out_valid;
    assign bus.cos_o       = r_cos;
    assign bus.sin_o       = r_sin;
endmodule

// File: tb/tb_cordic_sequencer.sv
// Scoreboard bench for cordic_sequencer with a behavioural cordic_slice
// closing the loop; results are checked bit-exact and against cos/sin.
module tb_cordic_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cordic_sequencer_if #(.N_FRAC(15)) bus ();

    logic signed [15:0] sx_o, sy_o, sz_o, sang_o;
    logic [3:0]         ssh_o;
    logic signed [15:0] sx_i, sy_i, sz_i;

    cordic_sequencer #(
        .N_FRAC(15), .BW_SHIFT_VALUE(4), .N_ITER(16), .X_INIT(19800)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus),
        .slice_x_o(sx_o),
        .slice_y_o(sy_o),
        .slice_z_o(sz_o),
        .slice_shift_o(ssh_o),
        .slice_angle_o(sang_o),
        .slice_x_i(sx_i),
        .slice_y_i(sy_i),
        .slice_z_i(sz_i)
    );

    // behavioural cordic_slice: one registered rotation-mode micro-step
    always_ff @(posedge clk) begin
        if (rst) begin
            sx_i <= '0;
            sy_i <= '0;
            sz_i <= '0;
        end else if (!sz_o[15]) begin
            sx_i <= sx_o - (sy_o >>> ssh_o);
            sy_i <= sy_o + (sx_o >>> ssh_o);
            sz_i <= sz_o - sang_o;
        end else begin
            sx_i <= sx_o + (sy_o >>> ssh_o);
            sy_i <= sy_o - (sx_o >>> ssh_o);
            sz_i <= sz_o + sang_o;
        end
    end

    typedef struct {
        logic signed [15:0] p;
        logic signed [15:0] c;
        logic signed [15:0] s;
        int                 ic;
        int                 is;
    } exp_t;

    exp_t sb[$];
    int   pulse_q[$];
    int   rc_q[$];
    int   rs_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    real  kx;
    int   atan_t[16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                         41, 20, 10, 5, 3, 1, 1, 0};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic signed [15:0] p);
        exp_t e;
        logic signed [15:0] x, y, z, xn, yn;
        int pi_ = p;
        real ph;
        x = 16'sd19800;
        y = '0;
        z = p;
        if (pi_ >= 16384) begin
            x = '0;
            y = 16'sd19800;
            z = 16'(pi_ - 16384);
        end else if (pi_ < -16384) begin
            x = '0;
            y = -16'sd19800;
            z = 16'(pi_ + 16384);
        end
        for (int i = 0; i < 16; i++) begin
            if (!z[15]) begin
                xn = x - (y >>> i);
                yn = y + (x >>> i);
                z  = z - 16'(atan_t[i]);
            end else begin
                xn = x + (y >>> i);
                yn = y - (x >>> i);
                z  = z + 16'(atan_t[i]);
            end
            x = xn;
            y = yn;
        end
        ph   = real'(pi_) * 3.141592653589793 / 32768.0;
        e.p  = p;
        e.c  = x;
        e.s  = y;
        e.ic = int'(kx * $cos(ph));
        e.is = int'(kx * $sin(ph));
        return e;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    always @(negedge clk) begin
        if (bus.out_valid_o) begin
            exp_t e;
            pulse_q.push_back(cyc);
            rc_q.push_back(int'(bus.cos_o));
            rs_q.push_back(int'(bus.sin_o));
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d cos=%0d sin=%0d, required no pulse",
                         cyc, bus.cos_o, bus.sin_o);
            end else begin
                e = sb.pop_front();
                if (bus.cos_o !== e.c || bus.sin_o !== e.s) begin
                    errors++;
                    $display("FAIL exact_result phase=%h got cos=%0d sin=%0d, required cos=%0d sin=%0d",
                             e.p, bus.cos_o, bus.sin_o, e.c, e.s);
                end
                checks++;
                if (iabs(int'(bus.cos_o) - e.ic) > 8 ||
                    iabs(int'(bus.sin_o) - e.is) > 8) begin
                    errors++;
                    $display("FAIL ideal_result phase=%h got cos=%0d sin=%0d, required cos=%0d sin=%0d +-8",
                             e.p, bus.cos_o, bus.sin_o, e.ic, e.is);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_obs();
        pulse_q.delete();
        rc_q.delete();
        rs_q.delete();
    endtask

    task automatic wait_pulses(input int n);
        for (int i = 0; i < 60 && pulse_q.size() < n; i++) tick();
    endtask

    task automatic send(input logic [15:0] p, input bit track, output int acc);
        acc = -1;
        bus.in_valid_i = 1'b1;
        bus.phase_i    = p;
        for (int i = 0; i < 60; i++) begin
            if (bus.in_ready_o) begin
                acc = cyc + 1;
                break;
            end
            tick();
        end
        if (acc >= 0 && track) sb.push_back(model(p));
        tick();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid_i = 1'b0;
        bus.phase_i    = '0;
        repeat (3) tick();
        checks++;
        if (bus.in_ready_o !== 1'b0 || bus.out_valid_o !== 1'b0 ||
            bus.cos_o !== 16'sd0 || bus.sin_o !== 16'sd0) begin
            errors++;
            $display("FAIL reset_state rdy=%b vld=%b cos=%0d sin=%0d, required 0 0 0 0",
                     bus.in_ready_o, bus.out_valid_o, bus.cos_o, bus.sin_o);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b, required 1", bus.in_ready_o);
        end
    endtask

    task automatic test_phases();
        logic [15:0] ph[5] = '{16'h0000, 16'h2000, 16'h4000, 16'hC000, 16'h8000};
        int acc;
        foreach (ph[k]) begin
            clear_obs();
            send(ph[k], 1'b1, acc);
            wait_pulses(1);
            checks++;
            if (acc < 0 || pulse_q.size() != 1) begin
                errors++;
                $display("FAIL pulse_timeout phase=%h acc=%0d pulses=%0d, required 1",
                         ph[k], acc, pulse_q.size());
            end else if (pulse_q[0] - acc != 17) begin
                errors++;
                $display("FAIL latency phase=%h got %0d, required 17",
                         ph[k], pulse_q[0] - acc);
            end
            repeat (3) tick();
        end
    endtask

    task automatic test_back_to_back();
        int acc1 = -1;
        int acc2 = -1;
        clear_obs();
        bus.in_valid_i = 1'b1;
        bus.phase_i    = 16'h1000;
        for (int i = 0; i < 60 && acc1 < 0; i++) begin
            if (bus.in_ready_o) acc1 = cyc + 1;
            else tick();
        end
        sb.push_back(model(16'h1000));
        tick();
        bus.phase_i = 16'hF000;
        for (int i = 0; i < 60 && acc2 < 0; i++) begin
            if (bus.in_ready_o) acc2 = cyc + 1;
            else tick();
        end
        sb.push_back(model(16'hF000));
        tick();
        bus.in_valid_i = 1'b0;
        wait_pulses(2);
        checks++;
        if (pulse_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_pulses got %0d, required 2", pulse_q.size());
        end else begin
            checks++;
            if (acc2 - acc1 != 18 || acc2 != pulse_q[0] + 1) begin
                errors++;
                $display("FAIL b2b_accept got gap=%0d at cyc %0d, required 18 at %0d",
                         acc2 - acc1, acc2, pulse_q[0] + 1);
            end
            checks++;
            if (pulse_q[1] - pulse_q[0] != 18) begin
                errors++;
                $display("FAIL b2b_spacing got %0d, required 18",
                         pulse_q[1] - pulse_q[0]);
            end
            checks++;
            if (iabs(rc_q[1] - rc_q[0]) > 8 || iabs(rs_q[1] + rs_q[0]) > 8) begin
                errors++;
                $display("FAIL b2b_symmetry got %0d/%0d, required %0d/%0d +-8",
                         rc_q[1], rs_q[1], rc_q[0], -rs_q[0]);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_valid_during_iter();
        int acc;
        int bad = 0;
        clear_obs();
        send(16'h2000, 1'b1, acc);
        for (int i = 0; i < 13; i++) begin
            bus.in_valid_i = 1'($urandom_range(0, 1));
            bus.phase_i    = 16'($urandom);
            tick();
            if (bus.in_ready_o !== 1'b0) bad++;
        end
        bus.in_valid_i = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ready_in_iter got %0d high cycles, required 0", bad);
        end
        wait_pulses(1);
        repeat (25) tick();
        checks++;
        if (pulse_q.size() != 1 || sb.size() != 0) begin
            errors++;
            $display("FAIL iter_ignore got pulses=%0d pending=%0d, required 1 0",
                     pulse_q.size(), sb.size());
        end
    endtask

    task automatic test_reset_abort();
        int acc;
        clear_obs();
        send(16'h1800, 1'b0, acc);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.in_ready_o !== 1'b0 || bus.cos_o !== 16'sd0 ||
            bus.sin_o !== 16'sd0) begin
            errors++;
            $display("FAIL abort_reset rdy=%b cos=%0d sin=%0d, required 0 0 0",
                     bus.in_ready_o, bus.cos_o, bus.sin_o);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready got %b, required 1", bus.in_ready_o);
        end
        repeat (30) tick();
        checks++;
        if (pulse_q.size() != 0 || bus.cos_o !== 16'sd0 || bus.sin_o !== 16'sd0) begin
            errors++;
            $display("FAIL abort_no_pulse pulses=%0d cos=%0d sin=%0d, required 0 0 0",
                     pulse_q.size(), bus.cos_o, bus.sin_o);
        end
        send(16'h0000, 1'b1, acc);
        wait_pulses(1);
        checks++;
        if (pulse_q.size() != 1 || pulse_q[0] - acc != 17) begin
            errors++;
            $display("FAIL after_abort pulses=%0d, required 1 at latency 17",
                     pulse_q.size());
        end
        repeat (3) tick();
    endtask

    initial begin
        kx = 19800.0;
        for (int i = 0; i < 16; i++) kx = kx * $sqrt(1.0 + 1.0 / (4.0 ** i));
        test_reset();
        test_phases();
        test_back_to_back();
        test_valid_during_iter();
        test_reset_abort();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_results got %0d pending, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d, required finish before time limit", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cordic_sequencer.md
# cordic_sequencer

Iterative control stage that sits directly upstream of `cordic_slice` and closes the loop around it. It accepts a phase word through a valid/ready handshake and applies a ±90° quadrant pre-rotation. It then feeds one `cordic_slice` instance for N_ITER clock cycles, driving the shift value and the arctangent constant each cycle and routing the slice outputs back to its inputs. At the end it returns a registered cos/sin pair with a one-cycle valid pulse.

## Interface
- N_FRAC, 15: fractional bits; all data words are signed N_FRAC+1 bits (Q1.15).
- BW_SHIFT_VALUE, 4: width of the slice shift-value port.
- N_ITER, 16: number of micro-rotations. Legal range 1..2^BW_SHIFT_VALUE.
- X_INIT, 19800: initial vector magnitude (≈0.6042). This pre-compensates the CORDIC gain of 1.6468 and gives a peak output of ≈32606, which leaves headroom.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  phase word valid.
- in_ready_o  out  1  high only in IDLE with rst_i low.
- phase_i  in  N_FRAC+1  signed angle. 0x8000 = −π, 0x4000 = +π/2; 2^N_FRAC corresponds to π.
- out_valid_o  out  1  one-cycle result pulse.
- cos_o, sin_o  out  N_FRAC+1  registered result; held until the next result.
- slice_x_o, slice_y_o, slice_z_o  out  N_FRAC+1  to slice x_i/y_i/z_i.
- slice_shift_o  out  BW_SHIFT_VALUE  to slice shift_value_i.
- slice_angle_o  out  N_FRAC+1  to slice current_rotation_angle_i.
- slice_x_i, slice_y_i, slice_z_i  in  N_FRAC+1  from slice x_o/y_o/z_o.

## Operation
- States:
  - IDLE: in_ready_o=1. A handshake (in_valid_i & in_ready_o) at an edge loads the init registers, clears cnt to 0 and moves to ITER.
  - ITER: cnt increments each edge. The edge at cnt=N_ITER−1 moves to CAPTURE.
  - CAPTURE: the edge loads cos_o←slice_x_i and sin_o←slice_y_i, sets out_valid_o=1 for the following cycle, and moves to IDLE.
- Quadrant pre-rotation at accept, with p = phase_i:
  - p ≥ 0x4000: x0=0, y0=+X_INIT, z0=p−0x4000.
  - p < −0x4000: x0=0, y0=−X_INIT, z0=p+0x4000.
  - Otherwise: x0=X_INIT, y0=0, z0=p.
  - Boundaries: 0x4000 takes the first branch; 0xC000 takes the direct branch; 0x8000 gives z0=0xC000.
- Slice drive:
  - slice_shift_o = cnt.
  - slice_angle_o = ATAN[cnt].
  - slice_{x,y,z}_o = init registers when state≠ITER or cnt=0; otherwise slice_{x,y,z}_i (feedback).
- ATAN[i] = round(atan(2^−i)/π·2^15) for i=0..15: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0. Entries beyond N_ITER are unused.
- Arithmetic: no widening. Vector magnitude never exceeds X_INIT·1.6468 < 2^15, so no overflow is possible. z wrap-around is the natural two's-complement wrap.
- in_valid_i outside IDLE is ignored; there is no queuing.
- out_valid_o does not wait for a ready; the consumer must take the result in the pulse cycle.

## Timing
- Reset values (rst_i high at an edge): state=IDLE, cnt=0, init registers=0, cos_o=0, sin_o=0, out_valid_o=0. in_ready_o=0 while rst_i is high.
- Reset mid-ITER or mid-CAPTURE aborts the operation: no out_valid_o pulse, and the next operation starts clean.
- Latency: with the accept at edge 0, the slice captures iterations at edges 1..N_ITER and CAPTURE registers the result at edge N_ITER+1. out_valid_o is high in the cycle after edge N_ITER+1, i.e. 17 cycles for the default N_ITER.
- Throughput: one result per N_ITER+2 cycles. in_ready_o is already high during the out_valid_o cycle, so a new accept may coincide with the pulse; back-to-back operations have no gap.
- The slice register is the only pipeline stage inside the loop. The sequencer adds no registers on slice_*_o, which are pure muxes of state and registers.

## Test plan
- Reset, then phase_i=0x0000 accepted: out_valid_o is high exactly 17 cycles after the accept; cos_o≈+32606 and sin_o≈0, each within ±8 LSB.
- phase_i=0x2000 (+π/4): cos_o≈sin_o≈+23056, each within ±8.
- Boundaries:
  - 0x4000 → cos≈0, sin≈+32606.
  - 0xC000 → cos≈0, sin≈−32606.
  - 0x8000 → cos≈−32606, sin≈0.
  - All within ±8.
- Back-to-back: in_valid_i held high with phases 0x1000 then 0xF000. Second accept happens in the first pulse cycle; pulses are 18 cycles apart; second result is the first with sin negated.
- in_valid_i toggled during ITER: ignored, in_ready_o stays 0, and the result is unaffected.
- rst_i asserted 5 cycles after an accept: no out_valid_o pulse ever appears, outputs are 0, and in_ready_o returns to 1 the cycle after rst_i drops.
